// File: rtl/simmem_pkg.sv
// Shared sizing constants and types for the simulated memory controller.
//   NumDelaySlots          - concurrently pending delayed write responses
//   DelayWidth             - width of a response delay, in cycles
//   WriteRespBankAddrWidth - width of a local write-response identifier
//   delay_slot_t           - one scheduler slot: busy flag, id, down-counter
package simmem_pkg;

  localparam int unsigned NumDelaySlots          = 4;
  localparam int unsigned DelayWidth             = 8;
  localparam int unsigned WriteRespBankAddrWidth = 3;

  typedef struct packed {
    logic                              busy;
    logic [WriteRespBankAddrWidth-1:0] id;
    logic [DelayWidth-1:0]             counter;
  } delay_slot_t;

endpackage

// File: rtl/simmem_first_one.sv
// Lowest-set-bit priority encoder.
//   in_i    - request vector
//   idx_o   - index of the lowest set bit (0 when none set)
//   found_o - at least one bit of in_i is set
module simmem_first_one #(
  parameter  int unsigned Width    = 4,
  localparam int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (in_i[i] && !found_o) begin
        idx_o   = IdxWidth'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_delay_scheduler.sv
// Holds write-response identifiers until their computed delay has elapsed,
// then presents them one at a time to the response bank.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   in_id_i, in_delay_i, in_valid_i, in_ready_o - new id/delay pair handshake
//   out_id_o, out_valid_o, out_ready_i          - expired id handshake
//   occupancy_o                                 - number of busy slots
module simmem_delay_scheduler #(
  parameter int unsigned NumSlots   = simmem_pkg::NumDelaySlots,
  parameter int unsigned IdWidth    = simmem_pkg::WriteRespBankAddrWidth,
  parameter int unsigned DelayWidth = simmem_pkg::DelayWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [IdWidth-1:0]            in_id_i,
  input  logic [DelayWidth-1:0]         in_delay_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [IdWidth-1:0]            out_id_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(NumSlots+1)-1:0] occupancy_o
);

  localparam int unsigned SlotIdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int unsigned OccWidth     = $clog2(NumSlots + 1);

  logic [NumSlots-1:0]     busy_q;
  logic [IdWidth-1:0]      id_q  [NumSlots];
  logic [DelayWidth-1:0]   cnt_q [NumSlots];
  logic                    lock_q;
  logic [SlotIdxWidth-1:0] lock_idx_q;

  logic [NumSlots-1:0]     free_vec;
  logic [NumSlots-1:0]     expired_vec;
  logic [SlotIdxWidth-1:0] free_idx;
  logic [SlotIdxWidth-1:0] expired_idx;
  logic                    free_found;
  logic                    expired_found;
  logic [SlotIdxWidth-1:0] sel_idx;
  logic                    accept;
  logic                    release_slot;

  always_comb begin
    free_vec    = '0;
    expired_vec = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      free_vec[i]    = !busy_q[i];
      expired_vec[i] = busy_q[i] && (cnt_q[i] == '0);
    end
  end

  simmem_first_one #(.Width(NumSlots)) u_free_sel (
    .in_i    (free_vec),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  simmem_first_one #(.Width(NumSlots)) u_expired_sel (
    .in_i    (expired_vec),
    .idx_o   (expired_idx),
    .found_o (expired_found)
  );

  // A locked slot keeps being presented until its handshake, so a
  // lower-index slot expiring meanwhile cannot change out_id_o.
  assign sel_idx      = lock_q ? lock_idx_q : expired_idx;
  assign out_valid_o  = lock_q || expired_found;
  assign out_id_o     = out_valid_o ? id_q[sel_idx] : '0;
  assign in_ready_o   = free_found;
  assign accept       = in_valid_i && free_found;
  assign release_slot = out_valid_o && out_ready_i;

  always_comb begin
    occupancy_o = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      occupancy_o = occupancy_o + OccWidth'(busy_q[i]);
    end
  end

  // Allocation only ever targets a slot that is free in the registered
  // state, so it never collides with the slot being released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int unsigned i = 0; i < NumSlots; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        if (busy_q[i] && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
        end
      end
      if (release_slot) begin
        busy_q[sel_idx] <= 1'b0;
        lock_q          <= 1'b0;
      end else if (out_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
      if (accept) begin
        busy_q[free_idx] <= 1'b1;
        id_q[free_idx]   <= in_id_i;
        cnt_q[free_idx]  <= in_delay_i;
      end
    end
  end

endmodule

// File: tb/tb_simmem_delay_scheduler.sv
module tb_simmem_delay_scheduler;

  localparam int NSLOTS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_id = '0;
  logic [7:0] in_delay = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out_id;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each slot remembers the absolute cycle from which it
  // counts as expired; "now" is the index of the current cycle.
  bit m_busy [NSLOTS];
  int m_id   [NSLOTS];
  int m_exp  [NSLOTS];
  bit m_lock;
  int m_lock_idx;
  int now;

  simmem_delay_scheduler #(
    .NumSlots   (4),
    .IdWidth    (3),
    .DelayWidth (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_id_i     (in_id),
    .in_delay_i  (in_delay),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_id_o    (out_id),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .occupancy_o (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NSLOTS; i++) begin
      m_busy[i] = 1'b0;
      m_id[i]   = 0;
      m_exp[i]  = 0;
    end
    m_lock     = 1'b0;
    m_lock_idx = 0;
  endfunction

  function automatic int model_presented();
    if (m_lock) return m_lock_idx;
    for (int i = 0; i < NSLOTS; i++)
      if (m_busy[i] && now >= m_exp[i]) return i;
    return -1;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < NSLOTS; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < NSLOTS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Entered at posedge+1: drive inputs, check at negedge, update model at posedge.
  task automatic do_cycle(input bit v, input int id, input int d, input bit rdy);
    int p;
    int f;
    in_valid  = v;
    in_id     = 3'(id);
    in_delay  = 8'(d);
    out_ready = rdy;
    @(negedge clk);
    p = model_presented();
    f = model_free();
    check_eq("in_ready",  32'(in_ready),  32'(f >= 0));
    check_eq("out_valid", 32'(out_valid), 32'(p >= 0));
    check_eq("out_id",    32'(out_id),    (p >= 0) ? 32'(m_id[p]) : 32'd0);
    check_eq("occupancy", 32'(occupancy), 32'(model_occ()));
    @(posedge clk);
    if (p >= 0 && rdy) begin
      m_busy[p] = 1'b0;
      m_lock    = 1'b0;
    end else if (p >= 0) begin
      m_lock     = 1'b1;
      m_lock_idx = p;
    end
    if (v && f >= 0) begin
      m_busy[f] = 1'b1;
      m_id[f]   = id;
      m_exp[f]  = now + 1 + d;
    end
    now++;
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 0, 0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_id"},    32'(out_id),    32'd0);
    check_eq({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    model_clear();
    now = 0;
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single entry, delay 5: presented 6 cycles after acceptance, then freed.
    do_cycle(1'b1, 3, 5, 1'b0);
    idle(5, 1'b0);
    check_eq("d5_valid", 32'(out_valid), 32'd1);
    check_eq("d5_id",    32'(out_id),    32'd3);
    idle(3, 1'b1);

    // Delay 0: presented on the very next cycle.
    do_cycle(1'b1, 1, 0, 1'b0);
    idle(2, 1'b1);

    // Fill all slots, fifth push ignored, one release reopens a slot.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, i, 20, 1'b0);
    do_cycle(1'b1, 6, 1, 1'b0);
    idle(20, 1'b0);
    do_cycle(1'b0, 0, 0, 1'b1);
    do_cycle(1'b1, 5, 2, 1'b0);
    idle(30, 1'b1);

    // Lower-index slot expiring while a higher one is held must not preempt it.
    do_cycle(1'b1, 4, 8, 1'b0);
    do_cycle(1'b1, 1, 40, 1'b0);
    do_cycle(1'b1, 7, 1, 1'b0);
    idle(12, 1'b0);
    check_eq("hold_id", 32'(out_id), 32'd7);
    do_cycle(1'b0, 0, 0, 1'b1);
    check_eq("next_id", 32'(out_id), 32'd4);
    idle(50, 1'b1);

    // Accept and release in the same cycle at occupancy 2.
    do_cycle(1'b1, 2, 0, 1'b0);
    do_cycle(1'b1, 6, 30, 1'b0);
    do_cycle(1'b1, 5, 3, 1'b1);
    check_eq("swap_occ", 32'(occupancy), 32'd2);
    idle(40, 1'b1);

    // Asynchronous reset in the middle of countdowns.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 4 + i, 10, 1'b0);
    idle(3, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    now++;
    #1;
    idle(20, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
               int'($urandom_range(0, 12)), $urandom_range(0, 9) < 6);
    end
    idle(30, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
